// File: rtl/platform_map_renderer_if.sv
// Configuration bus for platform_map_renderer: shadow-table writes and commit request.
interface platform_map_renderer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_idx;
  logic [9:0] cfg_x0;
  logic [9:0] cfg_y0;
  logic [5:0] cfg_len;
  logic       cfg_kind;
  logic       cfg_en;
  logic       cfg_commit;

  modport master (
    output cfg_valid, cfg_idx, cfg_x0, cfg_y0, cfg_len, cfg_kind, cfg_en, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_x0, cfg_y0, cfg_len, cfg_kind, cfg_en, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/platform_map_renderer.sv
// Platform tile renderer: double-buffered platform table, per-pixel hit test, 3-stage ROM pipeline.
// Optional horizontal tile scroll for kind-0 entries is enabled by defining PLATFORM_SCROLL_EN.
module platform_map_renderer #(
  parameter int          NUM_PLAT = 8,
  parameter logic [11:0] TRANSP   = 12'h6DE
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_video_on,
  input  logic [9:0]                    i_x,
  input  logic [9:0]                    i_y,
  input  logic                          i_frame_start,
  platform_map_renderer_if.slave        io_cfg,
  output logic [7:0]                    o_rom_addr,
  output logic                          o_rom_sel,
  input  logic [11:0]                   i_rom_data,
  output logic [11:0]                   o_rgb_out,
  output logic                          o_platforms_on
);

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [5:0] len;
    logic       kind;
    logic       en;
  } plat_t;

  plat_t       r_shadow [NUM_PLAT];
  plat_t       r_active [NUM_PLAT];
  logic        r_commit_pending;
  logic        w_copy;
  logic        w_wr;
  logic [3:0]  w_scroll;

  logic        w_hit;
  logic        w_sel;
  logic [7:0]  w_addr;
  logic        w_pix_on;

  logic [7:0]  r_rom_addr;
  logic        r_rom_sel;
  logic        r_hit1;
  logic        r_von1;
  logic        r_hit2;
  logic        r_von2;
  logic [11:0] r_rgb_out;
  logic        r_platforms_on;

  // Copy cycle blocks config writes so a write can never race the table swap.
  assign w_copy           = i_frame_start & r_commit_pending;
  assign io_cfg.cfg_ready = ~i_reset & ~w_copy;
  assign w_wr             = io_cfg.cfg_valid & io_cfg.cfg_ready;

  // Hit test in 11-bit arithmetic so entries near x/y=1023 do not wrap.
  function automatic logic f_hit(input plat_t e, input logic [9:0] px, input logic [9:0] py);
    logic [10:0] xs;
    logic [10:0] xe;
    logic [10:0] ys;
    logic [10:0] ye;
    xs = {1'b0, e.x0};
    xe = xs + {1'b0, e.len, 4'd0};
    ys = {1'b0, e.y0};
    ye = ys + 11'd16;
    return e.en && (e.len != 6'd0) &&
           ({1'b0, py} >= ys) && ({1'b0, py} < ye) &&
           ({1'b0, px} >= xs) && ({1'b0, px} < xe);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_commit_pending <= 1'b0;
    end else begin
      // Out-of-range indices match no entry and are silently dropped.
      for (int i = 0; i < NUM_PLAT; i++) begin
        if (w_wr && (io_cfg.cfg_idx == 4'(i))) begin
          r_shadow[i] <= {io_cfg.cfg_x0, io_cfg.cfg_y0, io_cfg.cfg_len, io_cfg.cfg_kind, io_cfg.cfg_en};
        end
        if (w_copy) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (w_copy) begin
        r_commit_pending <= 1'b0;
      end else if (io_cfg.cfg_commit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

`ifdef PLATFORM_SCROLL_EN
  logic [3:0] r_scroll;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scroll <= 4'd0;
    end else if (i_frame_start) begin
      r_scroll <= r_scroll + 4'd1;
    end
  end

  assign w_scroll = r_scroll;
`else
  assign w_scroll = 4'd0;
`endif

  // Descending scan: the last match assigned is the lowest index, which wins.
  always_comb begin
    w_hit  = 1'b0;
    w_sel  = 1'b0;
    w_addr = 8'd0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (f_hit(r_active[i], i_x, i_y)) begin
        w_hit  = 1'b1;
        w_sel  = r_active[i].kind;
        w_addr = {i_y[3:0] - r_active[i].y0[3:0],
                  i_x[3:0] - r_active[i].x0[3:0] + (r_active[i].kind ? 4'd0 : w_scroll)};
      end
    end
  end

  assign w_pix_on = r_hit2 & r_von2 & (i_rom_data != TRANSP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rom_addr     <= 8'd0;
      r_rom_sel      <= 1'b0;
      r_hit1         <= 1'b0;
      r_von1         <= 1'b0;
      r_hit2         <= 1'b0;
      r_von2         <= 1'b0;
      r_rgb_out      <= 12'h000;
      r_platforms_on <= 1'b0;
    end else begin
      r_rom_addr     <= w_addr;
      r_rom_sel      <= w_sel;
      r_hit1         <= w_hit;
      r_von1         <= i_video_on;
      r_hit2         <= r_hit1;
      r_von2         <= r_von1;
      r_platforms_on <= w_pix_on;
      r_rgb_out      <= w_pix_on ? i_rom_data : 12'h000;
    end
  end

  assign o_rom_addr     = r_rom_addr;
  assign o_rom_sel      = r_rom_sel;
  assign o_rgb_out      = r_rgb_out;
  assign o_platforms_on = r_platforms_on;

endmodule

// File: tb/tb_platform_map_renderer.sv
// Scoreboard bench for platform_map_renderer: directed pixels push expectations, a monitor checks them.
module tb_platform_map_renderer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  x = 10'd0;
  logic [9:0]  y = 10'd0;
  logic [11:0] rom_data;
  logic [7:0]  rom_addr;
  logic        rom_sel;
  logic [11:0] rgb_out;
  logic        platforms_on;

  int checks = 0;
  int failures = 0;
  int n_fs = 0;

  logic       drv_valid = 1'b0;
  logic [2:0] v_pipe = 3'b000;

  logic [8:0]  q_addr [$];
  logic [12:0] q_pix  [$];
  string       q_an   [$];
  string       q_pn   [$];

  platform_map_renderer_if u_if ();

  platform_map_renderer #(.NUM_PLAT(8), .TRANSP(12'h6DE)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_video_on     (video_on),
    .i_x            (x),
    .i_y            (y),
    .i_frame_start  (frame_start),
    .io_cfg         (u_if),
    .o_rom_addr     (rom_addr),
    .o_rom_sel      (rom_sel),
    .i_rom_data     (rom_data),
    .o_rgb_out      (rgb_out),
    .o_platforms_on (platforms_on)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_val(input logic sel, input logic [7:0] a);
    if (!sel && a == 8'h00) return 12'h123;
    else if (sel && a == 8'h00) return 12'h6DE;
    else return {3'b001, sel, a};
  endfunction

  always @(posedge clk) rom_data <= rom_val(rom_sel, rom_addr);

  always @(posedge clk) v_pipe <= {v_pipe[1:0], drv_valid};

  always @(negedge clk) begin
    logic [8:0]  ea;
    logic [12:0] ep;
    string       nm;
    if (v_pipe[0]) begin
      checks++;
      if (q_addr.size() == 0) begin
        failures++;
        $display("FAIL sb_addr_underflow got=%h expected=queued entry", {rom_addr, rom_sel});
      end else begin
        ea = q_addr.pop_front();
        nm = q_an.pop_front();
        if ({rom_addr, rom_sel} !== ea) begin
          failures++;
          $display("FAIL %s_addr got addr=%h sel=%b expected addr=%h sel=%b",
                   nm, rom_addr, rom_sel, ea[8:1], ea[0]);
        end
      end
    end
    if (v_pipe[2]) begin
      checks++;
      if (q_pix.size() == 0) begin
        failures++;
        $display("FAIL sb_pix_underflow got=%h expected=queued entry", {platforms_on, rgb_out});
      end else begin
        ep = q_pix.pop_front();
        nm = q_pn.pop_front();
        if ({platforms_on, rgb_out} !== ep) begin
          failures++;
          $display("FAIL %s_pix got on=%b rgb=%h expected on=%b rgb=%h",
                   nm, platforms_on, rgb_out, ep[12], ep[11:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sc();
`ifdef PLATFORM_SCROLL_EN
    return 4'(n_fs % 16);
`else
    return 4'd0;
`endif
  endfunction

  // Expected address of a kind-0 entry: scroll is added to the column.
  function automatic logic [7:0] k0(input logic [3:0] row, input logic [3:0] col);
    logic [3:0] c;
    c = col + sc();
    return {row, c};
  endfunction

  task automatic pix(input string nm, input logic [9:0] px, input logic [9:0] py, input logic von,
                     input logic hit, input logic [7:0] ea, input logic es);
    logic eon;
    eon = hit & von & (rom_val(es, ea) != 12'h6DE);
    x = px;
    y = py;
    video_on = von;
    drv_valid = 1'b1;
    q_addr.push_back({ea, es});
    q_an.push_back(nm);
    q_pix.push_back({eon, eon ? rom_val(es, ea) : 12'h000});
    q_pn.push_back(nm);
    tick();
    drv_valid = 1'b0;
    video_on = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [9:0] x0, input logic [9:0] y0,
                           input logic [5:0] len, input logic kind, input logic en);
    u_if.cfg_valid = 1'b1;
    u_if.cfg_idx = idx;
    u_if.cfg_x0 = x0;
    u_if.cfg_y0 = y0;
    u_if.cfg_len = len;
    u_if.cfg_kind = kind;
    u_if.cfg_en = en;
    tick();
    u_if.cfg_valid = 1'b0;
  endtask

  task automatic commit();
    u_if.cfg_commit = 1'b1;
    tick();
    u_if.cfg_commit = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_fs++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.cfg_valid = 1'b0;
    u_if.cfg_idx = 4'd0;
    u_if.cfg_x0 = 10'd0;
    u_if.cfg_y0 = 10'd0;
    u_if.cfg_len = 6'd0;
    u_if.cfg_kind = 1'b0;
    u_if.cfg_en = 1'b0;
    u_if.cfg_commit = 1'b0;

    repeat (3) tick();
    chk("rst_cfg_ready", int'(u_if.cfg_ready), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_rgb_out", int'(rgb_out), 0);
    chk("rst_platforms_on", int'(platforms_on), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_cfg_ready", int'(u_if.cfg_ready), 1);
    tick();

    // Single entry: origin, edges, blanking
    cfg_write(4'd0, 10'd16, 10'd132, 6'd9, 1'b0, 1'b1);
    commit();
    frame();
    pix("origin",      10'd16,  10'd132, 1'b1, 1'b1, k0(4'd0, 4'd0), 1'b0);
    pix("right_excl",  10'd160, 10'd132, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("right_last",  10'd159, 10'd132, 1'b1, 1'b1, k0(4'd0, 4'd15), 1'b0);
    pix("left_miss",   10'd15,  10'd132, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("top_miss",    10'd16,  10'd131, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("bottom_row",  10'd16,  10'd147, 1'b1, 1'b1, k0(4'd15, 4'd0), 1'b0);
    pix("bottom_miss", 10'd16,  10'd148, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("blanked",     10'd16,  10'd132, 1'b0, 1'b1, k0(4'd0, 4'd0), 1'b0);

    // Overlap priority, transparency, out-of-range index
    cfg_write(4'd2, 10'd100, 10'd200, 6'd1, 1'b1, 1'b1);
    cfg_write(4'd5, 10'd96, 10'd196, 6'd2, 1'b0, 1'b1);
    cfg_write(4'd12, 10'd500, 10'd400, 6'd4, 1'b0, 1'b1);
    commit();
    frame();
    pix("overlap_transp", 10'd100, 10'd200, 1'b1, 1'b1, 8'h00, 1'b1);
    pix("overlap_e2",     10'd110, 10'd205, 1'b1, 1'b1, 8'h5A, 1'b1);
    pix("overlap_e5",     10'd116, 10'd200, 1'b1, 1'b1, k0(4'd4, 4'd4), 1'b0);
    pix("idx_oob",        10'd500, 10'd400, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("e0_inner",       10'd20,  10'd140, 1'b1, 1'b1, k0(4'd8, 4'd4), 1'b0);

    // Shadow write without commit, then a mid-frame commit
    cfg_write(4'd0, 10'd300, 10'd300, 6'd2, 1'b0, 1'b1);
    frame();
    frame();
    pix("nocommit_old", 10'd16,  10'd132, 1'b1, 1'b1, k0(4'd0, 4'd0), 1'b0);
    pix("nocommit_new", 10'd300, 10'd300, 1'b1, 1'b0, 8'h00, 1'b0);
    commit();
    pix("pending_old",  10'd16,  10'd132, 1'b1, 1'b1, k0(4'd0, 4'd0), 1'b0);
    pix("pending_new",  10'd300, 10'd300, 1'b1, 1'b0, 8'h00, 1'b0);
    frame_start = 1'b1;
    #1;
    chk("copy_cfg_ready", int'(u_if.cfg_ready), 0);
    tick();
    frame_start = 1'b0;
    n_fs++;
    chk("after_copy_cfg_ready", int'(u_if.cfg_ready), 1);
    pix("commit_new",  10'd300, 10'd300, 1'b1, 1'b1, k0(4'd0, 4'd0), 1'b0);
    pix("commit_gone", 10'd16,  10'd132, 1'b1, 1'b0, 8'h00, 1'b0);

    // Many frames: scroll moves kind-0 tiles only
    repeat (17) frame();
    pix("scroll_k0", 10'd300, 10'd300, 1'b1, 1'b1, k0(4'd0, 4'd0), 1'b0);
    pix("scroll_k1", 10'd110, 10'd205, 1'b1, 1'b1, 8'h5A, 1'b1);

    // Reset with a commit pending
    cfg_write(4'd1, 10'd600, 10'd50, 6'd3, 1'b0, 1'b1);
    commit();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    tick();
    chk("mid_rst_cfg_ready", int'(u_if.cfg_ready), 0);
    chk("mid_rst_platforms_on", int'(platforms_on), 0);
    chk("mid_rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b0;
    n_fs = 0;
    pix("rst_old_gone",  10'd300, 10'd300, 1'b1, 1'b0, 8'h00, 1'b0);
    pix("rst_new_none",  10'd600, 10'd50,  1'b1, 1'b0, 8'h00, 1'b0);
    frame();
    pix("rst_no_copy",   10'd600, 10'd50,  1'b1, 1'b0, 8'h00, 1'b0);
    pix("rst_shadow_clr", 10'd110, 10'd205, 1'b1, 1'b0, 8'h00, 1'b0);

    repeat (5) tick();
    chk("sb_drained", q_addr.size() + q_pix.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
